// File: rtl/rlm_pkg.sv
// Shared types and default sizes for the run-length meter.
package rlm_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int DEPTH_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/rlm_fifo.sv
// Small FIFO with a registered head; push ignored when full unless popping, pop ignored when empty.
// Head updates on the same edge as the push/pop, so the value is ready one cycle after the write.
module rlm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_head;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_nxt;
  logic [AW:0]   w_cnt_nxt;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!full || w_pop);
  assign w_rd_nxt  = r_rd + AW'(w_pop);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign head      = r_head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_dat;
        r_wr        <= r_wr + AW'(1);
      end
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
      // The new head may be the entry being written this very cycle.
      if (w_cnt_nxt != '0)
        r_head <= (w_push && (w_rd_nxt == r_wr)) ? push_dat : r_mem[w_rd_nxt];
    end
  end
endmodule

// File: rtl/run_len_meter.sv
// Measures high runs of y into a FIFO of lengths; len_valid rises one cycle after the closing 0 sample.
// Optional y/z consistency checker enabled by RLM_YZ_CHECK_EN; a full FIFO with no pop drops the new length.
module run_len_meter
  import rlm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             z,
  input  logic             len_ready,
  output logic [CNT_W-1:0] len,
  output logic             len_valid,
  output logic             sat,
  output logic             drop,
  output logic             err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_drop;

  logic             w_close;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_close   = (r_state == RUN) && !y;
  assign w_pop     = !w_empty && len_ready;
  assign len_valid = !w_empty;
  assign sat       = r_sat;
  assign drop      = r_drop;

  rlm_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_close),
    .push_dat (r_cnt),
    .pop      (w_pop),
    .head     (len),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (y) begin
            r_state <= RUN;
            r_cnt   <= CNT_W'(1);
          end
        end
        RUN: begin
          if (y) begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_MAX - CNT_W'(1)) r_sat <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_close && w_full && !w_pop) r_drop <= 1'b1;
    end
  end

`ifdef RLM_YZ_CHECK_EN
  logic r_err;
  assign err = r_err;

  always_ff @(posedge clk) begin
    if (!rst) r_err <= 1'b0;
    else if (y == z) r_err <= 1'b1;
  end
`else
  logic w_unused_z;
  assign w_unused_z = z;
  assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_run_len_meter.sv
// Bench for run_len_meter: directed scenarios plus a randomized run against a queue-based model.
module tb_run_len_meter;
  localparam int CNT_W = 8;
  localparam int DEPTH = 2;
  localparam int MAXV  = 255;
`ifdef RLM_YZ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             y;
  logic             z;
  logic             len_ready;
  logic [CNT_W-1:0] len;
  logic             len_valid;
  logic             sat;
  logic             drop;
  logic             err;

  int errors = 0;
  int checks = 0;

  int q[$];
  int m_run;
  bit m_in_run;
  int m_len;
  bit m_sat;
  bit m_drop;
  bit m_err;

  always #5 clk = ~clk;

  run_len_meter #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .y         (y),
    .z         (z),
    .len_ready (len_ready),
    .len       (len),
    .len_valid (len_valid),
    .sat       (sat),
    .drop      (drop),
    .err       (err)
  );

  // One clock: drive inputs, advance the model across the edge, then settle past it.
  task automatic step(input logic yv, input logic zv, input logic rv, input logic sv);
    y = yv; z = zv; len_ready = rv; rst = sv;
    @(posedge clk);
    if (!sv) begin
      q.delete();
      m_in_run = 0; m_run = 0; m_len = 0;
      m_sat = 0; m_drop = 0; m_err = 0;
    end else begin
      if (q.size() > 0 && rv) void'(q.pop_front());
      if (m_in_run && !yv) begin
        if (q.size() < DEPTH) q.push_back(m_run > MAXV ? MAXV : m_run);
        else m_drop = 1;
      end
      if (yv) begin
        m_run    = m_in_run ? m_run + 1 : 1;
        m_in_run = 1;
        if (m_run >= MAXV) m_sat = 1;
      end else begin
        m_in_run = 0;
      end
      if (q.size() > 0) m_len = q[0];
      if (CHK && (yv == zv)) m_err = 1;
    end
    #1;
  endtask

  task automatic run(input logic yv, input logic rv);
    step(yv, ~yv, rv, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    y = 1'b1; z = 1'b0; len_ready = 1'b0;
    do_reset();
    do_reset();
    checks++; if (len !== 8'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", len); end
    checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL reset_len_valid: got %b want 0", len_valid); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_single_run();
    do_reset();
    repeat (3) run(1'b1, 1'b1);
    checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", len_valid); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b1 || len !== 8'd3) begin errors++; $display("FAIL single_out: got valid=%b len=%0d want valid=1 len=3", len_valid, len); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got valid=%b want 0", len_valid); end
    checks++; if (len !== 8'd3) begin errors++; $display("FAIL single_hold: got len=%0d want 3", len); end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (2) run(1'b1, 1'b0);
    run(1'b0, 1'b0);
    repeat (4) run(1'b1, 1'b0);
    run(1'b0, 1'b0);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL bp_no_drop_yet: got %b want 0", drop); end
    repeat (5) run(1'b1, 1'b0);
    run(1'b0, 1'b0);
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL bp_drop: got %b want 1", drop); end
    checks++; if (len_valid !== 1'b1 || len !== 8'd2) begin errors++; $display("FAIL bp_head: got valid=%b len=%0d want valid=1 len=2", len_valid, len); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b1 || len !== 8'd4) begin errors++; $display("FAIL bp_second: got valid=%b len=%0d want valid=1 len=4", len_valid, len); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid=%b want 0", len_valid); end
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL bp_drop_sticky: got %b want 1", drop); end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (254) run(1'b1, 1'b1);
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL sat_early: got %b want 0", sat); end
    repeat (46) run(1'b1, 1'b1);
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_set: got %b want 1", sat); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b1 || len !== 8'd255) begin errors++; $display("FAIL sat_len: got valid=%b len=%0d want valid=1 len=255", len_valid, len); end
    repeat (3) run(1'b0, 1'b1);
    checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", sat); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    do_reset();
    seen = 0;
    repeat (2) run(1'b1, 1'b1);
    if (len_valid) seen++;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    if (len_valid) seen++;
    repeat (4) begin
      run(1'b1, 1'b1);
      if (len_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_early_out: got %0d valid cycles want 0", seen); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b1 || len !== 8'd4) begin errors++; $display("FAIL midrst_len: got valid=%b len=%0d want valid=1 len=4", len_valid, len); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL midrst_single: got valid=%b want 0", len_valid); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    run(1'b1, 1'b0); run(1'b0, 1'b0);
    run(1'b1, 1'b0); run(1'b1, 1'b0); run(1'b0, 1'b0);
    repeat (3) run(1'b1, 1'b0);
    checks++; if (len_valid !== 1'b1 || len !== 8'd1) begin errors++; $display("FAIL full_head: got valid=%b len=%0d want valid=1 len=1", len_valid, len); end
    run(1'b0, 1'b1);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL full_no_drop: got %b want 0", drop); end
    checks++; if (len !== 8'd2) begin errors++; $display("FAIL full_next: got len=%0d want 2", len); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b1 || len !== 8'd3) begin errors++; $display("FAIL full_last: got valid=%b len=%0d want valid=1 len=3", len_valid, len); end
    run(1'b0, 1'b1);
    checks++; if (len_valid !== 1'b0 || len !== 8'd3) begin errors++; $display("FAIL full_empty: got valid=%b len=%0d want valid=0 len=3", len_valid, len); end
  endtask

  task automatic test_err();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (err !== CHK) begin errors++; $display("FAIL err_set: got %b want %b", err, CHK); end
    repeat (3) run(1'b0, 1'b1);
    checks++; if (err !== CHK) begin errors++; $display("FAIL err_sticky: got %b want %b", err, CHK); end
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
  endtask

  task automatic test_random();
    logic yv;
    logic zv;
    logic rv;
    int   stay;
    do_reset();
    yv = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      stay = (i % 1000 < 400) ? 30 : 6;
      if ($urandom_range(0, stay) == 0) yv = ~yv;
      rv = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      zv = ($urandom_range(0, 150) == 0) ? yv : ~yv;
      if ($urandom_range(0, 700) == 0) step(yv, zv, rv, 1'b0);
      else step(yv, zv, rv, 1'b1);
      checks++;
      if (len_valid !== (q.size() > 0) || len !== CNT_W'(m_len) || sat !== m_sat ||
          drop !== m_drop || err !== m_err) begin
        errors++;
        $display("FAIL rand_cycle%0d: got valid=%b len=%0d sat=%b drop=%b err=%b want valid=%b len=%0d sat=%b drop=%b err=%b",
                 i, len_valid, len, sat, drop, err, (q.size() > 0), m_len, m_sat, m_drop, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_backpressure();
    test_saturate();
    test_reset_mid_run();
    test_full_push_pop();
    test_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/run_len_meter.md
RUN_LEN_METER -- requirements
Module: run_len_meter

Interface
REQ-001 CNT_W, 8, run-length counter and output width in bits (legal 2..16).
REQ-002 DEPTH, 2, output buffer depth in entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset: sampled on posedge clk, asserted when 0.
REQ-005 y  input  1  level from the upstream state-indicator FSM; 1 = "active".
REQ-006 z  input  1  complementary level from the same FSM (nominally ~y).
REQ-007 len  output  CNT_W  length in cycles of the oldest buffered high run of y.
REQ-008 len_valid  output  1  buffer non-empty; len is meaningful.
REQ-009 len_ready  input  1  consumer accepts len when len_valid && len_ready at posedge.
REQ-010 sat  output  1  sticky: some run reached the counter ceiling.
REQ-011 drop  output  1  sticky: a completed run was discarded because the buffer was full.
REQ-012 err  output  1  sticky y/z consistency error (tied 0 when the checker is compiled out).

Function
REQ-013 y shall be sampled once per posedge clk; a run is a maximal sequence of consecutive samples equal to 1.
REQ-014 The FSM shall have two states: IDLE (no run open) and RUN (run open, counting).
REQ-015 IDLE with y=1: go to RUN, cnt=1. IDLE with y=0: stay, cnt unchanged.
REQ-016 RUN with y=1: stay, cnt=cnt+1, saturating at 2^CNT_W-1; reaching the ceiling sets sat.
REQ-017 RUN with y=0: push cnt into the buffer, go to IDLE; len_valid shall rise on the next posedge (1-cycle latency from the closing sample).
REQ-018 Runs longer than 2^CNT_W-1 cycles shall report exactly 2^CNT_W-1.
REQ-019 The buffer shall be FIFO: len shows the oldest entry; a pop occurs on a posedge with len_valid && len_ready.
REQ-020 Push while full without a same-cycle pop: discard the new length, set drop, leave contents unchanged.
REQ-021 Push and pop in the same cycle while full: both take effect, no drop.
REQ-022 Pop while empty shall be ignored; len holds its last value and len_valid stays 0.
REQ-023 len and len_valid shall be registered outputs with no combinational path from y, z or len_ready.
REQ-024 Sticky flags shall clear only on reset.

Reset
REQ-025 With rst=0 at a posedge: state IDLE, cnt=0, buffer empty, len=0, len_valid=0, sat=0, drop=0, err=0.
REQ-026 Reset during RUN shall discard the open run; no length is pushed for it.
REQ-027 After rst returns to 1, the first sample of y=1 opens a new run with cnt=1.

Configuration
REQ-028 Macro RLM_YZ_CHECK_EN: when defined, err shall be set at any posedge outside reset where y==z.
REQ-029 RLM_YZ_CHECK_EN undefined: no checker logic; err is constant 0; z is unused.

Structure
REQ-030 Package rlm_pkg shall hold the state enum (IDLE, RUN) and the CNT_W and DEPTH default constants.
REQ-031 The buffer shall be a sub-module rlm_fifo (parameterised by width and depth; push, pop, full, empty).

Verification (CNT_W=8, DEPTH=2, len_ready=1 unless stated)
REQ-032 Reset, then y=1 for 3 cycles, then 0 -> len=3 and len_valid=1 for one cycle, starting one cycle after the first 0 sample.
REQ-033 len_ready=0; runs of 2, 4 and 5 cycles separated by 0s -> buffer holds 2,4 and drop=1; raising len_ready yields 2 then 4.
REQ-034 y=1 for 300 cycles -> len=255 and sat=1.
REQ-035 Reset pulsed at cycle 2 of a run, y stays 1 for 4 more cycles, then 0 -> single output len=4, no earlier output.
REQ-036 RLM_YZ_CHECK_EN defined, y=z=1 for one cycle -> err=1 and stays 1 until reset; macro undefined -> err=0.
REQ-037 Buffer full with len_ready=1 and a run closing in the same cycle -> drop=0 and the new length is the last output.
